// File: rtl/icb_master.sv
// Single-outstanding ICB bus master: accepts one user request, issues it on the
// ICB command channel, waits for the response and reports a one-cycle completion.
`timescale 1ns/1ps
module icb_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_read,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_timeout,
  output logic                busy,
  output logic                icb_cmd_valid,
  input  logic                icb_cmd_ready,
  output logic                icb_cmd_read,
  output logic [ADDR_W-1:0]   icb_cmd_addr,
  output logic [DATA_W-1:0]   icb_cmd_wdata,
  output logic [DATA_W/8-1:0] icb_cmd_wmask,
  input  logic                icb_rsp_valid,
  output logic                icb_rsp_ready,
  input  logic [DATA_W-1:0]   icb_rsp_rdata,
  input  logic                icb_rsp_err
);

  localparam int          MASK_W   = DATA_W / 8;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_wait_cnt;
  logic [15:0]         w_wait_cnt_nxt;
  logic                w_req_hs;
  logic                w_cmd_hs;
  logic                w_rsp_hs;
  logic                w_timeout;
  logic                w_done_ok;
  logic                w_done_to;

  logic                r_cmd_read;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic [MASK_W-1:0]   r_cmd_wmask;

  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_resp_timeout;

  assign w_req_hs  = req_valid & (r_state == IDLE);
  assign w_cmd_hs  = icb_cmd_ready & (r_state == CMD);
  assign w_rsp_hs  = icb_rsp_valid & (r_state == RSP);
  // Timeout fires on the last of TIMEOUT_CYC cycles spent waiting in one phase.
  assign w_timeout = (r_wait_cnt >= CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state, completion strobes and wait counter; handshakes win over timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_done_ok      = 1'b0;
    w_done_to      = 1'b0;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_req_hs) begin
          w_state_nxt = CMD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CMD: begin
        if (w_cmd_hs) begin
          w_state_nxt = RSP;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_done_to   = 1'b1;
        end else begin
          w_state_nxt = CMD;
        end
      end
      RSP: begin
        if (w_rsp_hs) begin
          w_state_nxt = IDLE;
          w_done_ok   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_done_to   = 1'b1;
        end else begin
          w_state_nxt = RSP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_wait_cnt_nxt = 16'd0;
    end else if (r_state == IDLE) begin
      w_wait_cnt_nxt = 16'd0;
    end else if (r_wait_cnt != CNT_MAX) begin
      w_wait_cnt_nxt = r_wait_cnt + 16'd1;
    end else begin
      w_wait_cnt_nxt = r_wait_cnt;
    end
  end

  // Command fields stay on the bus after the handshake: the responder decodes
  // its error status from the address it currently sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_read  <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_wmask <= '0;
    end else if (w_req_hs) begin
      r_cmd_read  <= req_read;
      r_cmd_addr  <= req_addr;
      r_cmd_wdata <= req_wdata;
      r_cmd_wmask <= req_wmask;
    end else begin
      r_cmd_read  <= r_cmd_read;
      r_cmd_addr  <= r_cmd_addr;
      r_cmd_wdata <= r_cmd_wdata;
      r_cmd_wmask <= r_cmd_wmask;
    end
  end

  // Completion status, held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_err     <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_resp_valid <= w_done_ok | w_done_to;
      if (w_done_ok) begin
        r_resp_err     <= icb_rsp_err;
        r_resp_timeout <= 1'b0;
        if (r_cmd_read) begin
          r_resp_rdata <= icb_rsp_rdata;
        end else begin
          r_resp_rdata <= r_resp_rdata;
        end
      end else if (w_done_to) begin
        r_resp_err     <= 1'b1;
        r_resp_timeout <= 1'b1;
      end else begin
        r_resp_err     <= r_resp_err;
        r_resp_timeout <= r_resp_timeout;
      end
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign icb_cmd_valid = (r_state == CMD);
  assign icb_rsp_ready = (r_state == RSP);
  assign icb_cmd_read  = r_cmd_read;
  assign icb_cmd_addr  = r_cmd_addr;
  assign icb_cmd_wdata = r_cmd_wdata;
  assign icb_cmd_wmask = r_cmd_wmask;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign resp_timeout  = r_resp_timeout;

endmodule

// File: tb/tb_icb_master.sv
// Directed bench for icb_master: a register-model responder for the main instance
// and a never-ready bus for a second instance built with an 8-cycle timeout.
`timescale 1ns/1ps
module tb_icb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_err, resp_timeout, busy;
  logic [63:0] resp_rdata;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [63:0] icb_rsp_rdata;

  logic        t_req_valid, t_req_ready, t_resp_valid, t_resp_err, t_resp_timeout, t_busy;
  logic [63:0] t_resp_rdata;
  logic        t_cmd_valid, t_cmd_read, t_rsp_ready;
  logic [31:0] t_cmd_addr;
  logic [63:0] t_cmd_wdata;
  logic [7:0]  t_cmd_wmask;
  logic        t_cmd_ready, t_rsp_valid, t_rsp_err;
  logic [63:0] t_rsp_rdata;

  logic        cmd_rdy_en, rsp_hold, stray_rsp, rsp_pend;
  logic [63:0] rsp_data;
  logic [63:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icb_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .busy(busy),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
  );

  icb_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .resp_timeout(t_resp_timeout), .busy(t_busy),
    .icb_cmd_valid(t_cmd_valid), .icb_cmd_ready(t_cmd_ready), .icb_cmd_read(t_cmd_read),
    .icb_cmd_addr(t_cmd_addr), .icb_cmd_wdata(t_cmd_wdata), .icb_cmd_wmask(t_cmd_wmask),
    .icb_rsp_valid(t_rsp_valid), .icb_rsp_ready(t_rsp_ready),
    .icb_rsp_rdata(t_rsp_rdata), .icb_rsp_err(t_rsp_err)
  );

  assign t_cmd_ready = 1'b0;
  assign t_rsp_valid = 1'b0;
  assign t_rsp_err   = 1'b0;
  assign t_rsp_rdata = 64'd0;

  // Zero-wait register-model responder; 0x20000008 is read-only (writes error)
  assign icb_cmd_ready = cmd_rdy_en;
  assign icb_rsp_valid = (rsp_pend & ~rsp_hold) | stray_rsp;
  assign icb_rsp_rdata = rsp_data;
  assign icb_rsp_err   = (icb_cmd_addr == 32'h2000_0008) & ~icb_cmd_read;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      rsp_data <= 64'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
    end else if (icb_cmd_valid && icb_cmd_ready) begin
      rsp_pend <= 1'b1;
      rsp_data <= mem[icb_cmd_addr[6:3]];
      if (!icb_cmd_read && icb_cmd_addr != 32'h2000_0008) begin
        for (int b = 0; b < 8; b++)
          if (!icb_cmd_wmask[b]) mem[icb_cmd_addr[6:3]][b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
      end
    end else if (icb_rsp_valid && icb_rsp_ready) begin
      rsp_pend <= 1'b0;
    end
  end

  task automatic issue(input logic rd, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    req_valid = 1'b1; req_read = rd; req_addr = a; req_wdata = d; req_wmask = m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      if (resp_valid === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; t_req_valid = 1'b0; req_read = 1'b0;
    req_addr = 32'd0; req_wdata = 64'd0; req_wmask = 8'd0;
    cmd_rdy_en = 1'b1; rsp_hold = 1'b0; stray_rsp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || icb_cmd_valid !== 1'b0 || icb_rsp_ready !== 1'b0 || resp_valid !== 1'b0 ||
        icb_cmd_addr !== 32'd0 || icb_cmd_wdata !== 64'd0 || icb_cmd_wmask !== 8'd0 || icb_cmd_read !== 1'b0 ||
        resp_rdata !== 64'd0 || resp_err !== 1'b0 || resp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b cv=%b rr=%b rv=%b addr=%h rdata=%h err=%b to=%b (want all 0)",
               busy, icb_cmd_valid, icb_rsp_ready, resp_valid, icb_cmd_addr, resp_rdata, resp_err, resp_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b busy=%b (want 1 0)", req_ready, busy);
    end
  endtask

  task automatic test_write_read();
    int n;
    issue(1'b0, 32'h2000_0020, 64'h0123_4567_89AB_CDEF, 8'h00);
    checks++;
    if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h2000_0020 || icb_cmd_read !== 1'b0 ||
        icb_cmd_wdata !== 64'h0123_4567_89AB_CDEF || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_n1: cv=%b addr=%h rd=%b wdata=%h busy=%b rdy=%b (want 1 20000020 0 0123456789abcdef 1 0)",
               icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, busy, req_ready);
    end
    @(negedge clk);
    checks++;
    if (icb_cmd_valid !== 1'b0 || icb_rsp_valid !== 1'b1 || icb_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_n2: cv=%b rspv=%b rspr=%b (want 0 1 1)", icb_cmd_valid, icb_rsp_valid, icb_rsp_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_err !== 1'b0 || resp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wr_n3: rv=%b rdy=%b err=%b to=%b (want 1 1 0 0)", resp_valid, req_ready, resp_err, resp_timeout);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || icb_cmd_addr !== 32'h2000_0020 || icb_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse_hold: rv=%b addr=%h rspr=%b (want 0 20000020 0)", resp_valid, icb_cmd_addr, icb_rsp_ready);
    end
    issue(1'b1, 32'h2000_0020, 64'd0, 8'h00);
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_rdata !== 64'h0123_4567_89AB_CDEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_back: cycle=%0d rdata=%h err=%b (want 3 0123456789abcdef 0)", n, resp_rdata, resp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_masked_write();
    int n;
    issue(1'b0, 32'h2000_0030, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    checks++;
    if (icb_cmd_wmask !== 8'hF0) begin
      errors++;
      $display("FAIL mask_bus: wmask=%h (want f0)", icb_cmd_wmask);
    end
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_rdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL mask_wr_hold: cycle=%0d rdata=%h (want 3 0123456789abcdef)", n, resp_rdata);
    end
    @(negedge clk);
    issue(1'b1, 32'h2000_0030, 64'd0, 8'h00);
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_rdata !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL mask_rd: cycle=%0d rdata=%h (want 3 00000000ffffffff)", n, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_error();
    int n;
    issue(1'b0, 32'h2000_0008, 64'h1111_2222_3333_4444, 8'h00);
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_err !== 1'b1 || resp_timeout !== 1'b0 || resp_rdata !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL err_resp: cycle=%0d err=%b to=%b rdata=%h (want 3 1 0 00000000ffffffff)",
               n, resp_err, resp_timeout, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if (resp_err !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_hold: err=%b rv=%b (want 1 0)", resp_err, resp_valid);
    end
  endtask

  task automatic test_back_pressure();
    int n;
    int bad;
    bad = 0;
    cmd_rdy_en = 1'b0;
    issue(1'b0, 32'h2000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h2000_0010 || icb_cmd_wdata !== 64'hDEAD_BEEF_CAFE_F00D ||
          icb_cmd_wmask !== 8'h3C || icb_cmd_read !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable[%0d]: cv=%b addr=%h wdata=%h wmask=%h busy=%b rv=%b (want 1 20000010 deadbeefcafef00d 3c 1 0)",
                 i, icb_cmd_valid, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, busy, resp_valid);
      end
      @(negedge clk);
    end
    cmd_rdy_en = 1'b1;
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_err !== 1'b0 || resp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: cycle=%0d err=%b to=%b (want 3 0 0)", n, resp_err, resp_timeout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    issue(1'b1, 32'h2000_0020, 64'd0, 8'h00);
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_rdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL b2b_first: cycle=%0d rdata=%h (want 3 0123456789abcdef)", n, resp_rdata);
    end
    issue(1'b1, 32'h2000_0030, 64'd0, 8'h00);
    checks++;
    if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h2000_0030 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: cv=%b addr=%h rv=%b (want 1 20000030 0)", icb_cmd_valid, icb_cmd_addr, resp_valid);
    end
    wait_resp(16, n);
    checks++;
    if (n !== 3 || resp_rdata !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL b2b_second: cycle=%0d rdata=%h (want 3 00000000ffffffff)", n, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_stray_rsp();
    stray_rsp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL stray_idle[%0d]: rv=%b busy=%b rdy=%b (want 0 0 1)", i, resp_valid, busy, req_ready);
      end
    end
    stray_rsp = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    int at;
    req_read = 1'b0; req_addr = 32'h2000_0040; req_wdata = 64'h0000_0000_0000_00A5; req_wmask = 8'h0F;
    t_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_req_valid = 1'b0;
    checks++;
    if (t_cmd_addr !== 32'h2000_0040 || {t_cmd_read, t_cmd_wmask, t_cmd_wdata} !== {1'b0, 8'h0F, 64'h0000_0000_0000_00A5} ||
        t_rsp_ready !== 1'b0 || t_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL to_cmd: addr=%h rd=%b wmask=%h wdata=%h rspr=%b rdy=%b (want 20000040 0 0f a5 0 0)",
               t_cmd_addr, t_cmd_read, t_cmd_wmask, t_cmd_wdata, t_rsp_ready, t_req_ready);
    end
    cnt = 0;
    at = -1;
    for (int i = 1; i <= 20; i++) begin
      if (t_resp_valid === 1'b1) begin
        at = i;
        break;
      end
      if (t_cmd_valid === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++;
    if (at !== 9 || cnt !== 8) begin
      errors++;
      $display("FAIL to_timing: resp_cycle=%0d cmd_cycles=%0d (want 9 8)", at, cnt);
    end
    checks++;
    if (t_resp_err !== 1'b1 || t_resp_timeout !== 1'b1 || t_req_ready !== 1'b1 || t_busy !== 1'b0 ||
        t_cmd_valid !== 1'b0 || t_resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL to_status: err=%b to=%b rdy=%b busy=%b cv=%b rdata=%h (want 1 1 1 0 0 0)",
               t_resp_err, t_resp_timeout, t_req_ready, t_busy, t_cmd_valid, t_resp_rdata);
    end
    @(negedge clk);
    checks++;
    if (t_resp_valid !== 1'b0 || t_resp_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: rv=%b to=%b (want 0 1)", t_resp_valid, t_resp_timeout);
    end
  endtask

  task automatic test_reset_in_rsp();
    rsp_hold = 1'b1;
    issue(1'b1, 32'h2000_0020, 64'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || icb_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rsp_setup: busy=%b rspr=%b (want 1 1)", busy, icb_rsp_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || icb_cmd_valid !== 1'b0 || icb_rsp_ready !== 1'b0 || icb_cmd_addr !== 32'd0 ||
        icb_cmd_read !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp_async: busy=%b cv=%b rspr=%b addr=%h rd=%b rv=%b rdata=%h err=%b (want all 0)",
               busy, icb_cmd_valid, icb_rsp_ready, icb_cmd_addr, icb_cmd_read, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_hold = 1'b0;
    stray_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_timeout !== 1'b0) begin
        errors++;
        $display("FAIL rst_rsp_after[%0d]: rv=%b busy=%b rdy=%b to=%b (want 0 0 1 0)",
                 i, resp_valid, busy, req_ready, resp_timeout);
      end
    end
    stray_rsp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_error();
    test_back_pressure();
    test_back_to_back();
    test_stray_rsp();
    test_timeout();
    test_reset_in_rsp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t (want finished)", $time);
    $fatal(1);
  end

endmodule

// File: doc/icb_master.md
ICB_MASTER -- requirements
Module: icb_master

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32, meaning ICB address width.
- REQ-002 SHALL have parameter DATA_W, default 64, meaning ICB data width; wmask width is DATA_W/8.
- REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning max wait cycles per phase; range 1 to 65535.
- REQ-004 SHALL have port clk, input, 1, the only clock; all logic on rising edge.
- REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
- REQ-006 SHALL have port req_valid, input, 1, user request valid.
- REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
- REQ-008 SHALL have port req_read, input, 1, 1 = read, 0 = write.
- REQ-009 SHALL have ports req_addr, req_wdata and req_wmask, inputs, widths ADDR_W / DATA_W / DATA_W/8, carrying the request fields.
- REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
- REQ-011 SHALL have port resp_rdata, output, DATA_W, carrying the read data.
- REQ-012 SHALL have ports resp_err and resp_timeout, outputs, 1 each, carrying completion status.
- REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
- REQ-014 SHALL have ICB command ports icb_cmd_valid (out, 1), icb_cmd_ready (in, 1), icb_cmd_read (out, 1), icb_cmd_addr (out, ADDR_W), icb_cmd_wdata (out, DATA_W) and icb_cmd_wmask (out, DATA_W/8).
- REQ-015 SHALL have ICB response ports icb_rsp_valid (in, 1), icb_rsp_ready (out, 1), icb_rsp_rdata (in, DATA_W) and icb_rsp_err (in, 1).

Function
- REQ-016 SHALL implement FSM states IDLE, CMD and RSP.
  - IDLE→CMD on req handshake.
  - CMD→RSP on icb_cmd_valid and icb_cmd_ready both high.
  - RSP→IDLE on icb_rsp_valid, or on timeout.
  - CMD→IDLE on timeout.
- REQ-017 SHALL drive req_ready high only in IDLE; at most one outstanding transaction.
- REQ-018 SHALL latch req_read, req_addr, req_wdata and req_wmask on the accept edge and drive them from registers on icb_cmd_*.
- REQ-019 SHALL pass wmask through unchanged: bit i = 1 means byte i is masked (not written).
- REQ-020 SHALL assert icb_cmd_valid exactly while in CMD, with all cmd fields stable until the handshake.
- REQ-021 SHALL keep icb_cmd_addr and icb_cmd_read holding the last command through RSP and IDLE until the next accept, because the responder derives icb_rsp_err from the current address.
- REQ-022 SHALL assert icb_rsp_ready exactly while in RSP.
- REQ-023 SHALL, on icb_rsp_valid in RSP, register the completion values on that edge:
  - resp_rdata = icb_rsp_rdata on reads; resp_rdata holds its previous value on writes.
  - resp_err = icb_rsp_err.
  - resp_timeout = 0.
  - resp_valid = 1 for exactly one cycle.
- REQ-024 SHALL hold resp_rdata, resp_err and resp_timeout until the next completion.
- REQ-025 SHALL use a wait counter that clears on every state change and increments each cycle in CMD or RSP.
  - When the counter reaches TIMEOUT_CYC without the awaited handshake, the block SHALL pulse resp_valid with resp_err = 1 and resp_timeout = 1, and return to IDLE.
  - The counter SHALL saturate and never wrap.
- REQ-026 SHALL give priority to a handshake over a timeout when both occur in the same cycle.
- REQ-027 SHALL ignore icb_rsp_valid when not in RSP (no state change, no resp_valid).
- REQ-028 SHALL meet this latency with a zero-wait responder:
  - accept at edge N → icb_cmd_valid high in cycle N+1;
  - responder rsp_valid high in cycle N+2;
  - resp_valid high in cycle N+3;
  - req_ready high again in cycle N+3.
- REQ-029 SHALL allow req_valid in the same cycle as resp_valid; that request is accepted on that edge.

Reset
- REQ-030 SHALL, while rst_n is low, force:
  - state = IDLE;
  - icb_cmd_valid = 0 and icb_rsp_ready = 0;
  - icb_cmd_read = 0, icb_cmd_addr = 0, icb_cmd_wdata = 0 and icb_cmd_wmask = 0;
  - resp_valid = 0, resp_rdata = 0, resp_err = 0 and resp_timeout = 0;
  - busy = 0, and req_ready = 1 once rst_n is high;
  - wait counter = 0.
- REQ-031 SHALL, on reset assertion mid-transaction, abort the transaction immediately; no resp_valid is produced for it after release.

Verification
- REQ-032 Write then read:
  - Stimulus: write addr 0x20000020, wdata 0x0123456789ABCDEF, wmask 0x00; then read the same address from a register-model responder.
  - Required response: resp_rdata = 0x0123456789ABCDEF, resp_err = 0, and the REQ-028 cycle timing.
- REQ-033 Masked write:
  - Stimulus: wmask 0xF0, wdata 0xFFFFFFFFFFFFFFFF.
  - Required response: icb_cmd_wmask = 0xF0 on the bus, and a readback of 0x00000000FFFFFFFF from the model.
- REQ-034 Back-pressure:
  - Stimulus: write to 0x20000010 with icb_cmd_ready held low for 10 cycles.
  - Required response: icb_cmd_valid and the fields stay stable for all 10 cycles, busy = 1, and completion has resp_err = 0.
- REQ-035 Error response:
  - Stimulus: write to 0x20000008 (read-only).
  - Required response: resp_err = 1 and resp_timeout = 0.
- REQ-036 Timeout:
  - Stimulus: TIMEOUT_CYC = 8, icb_cmd_ready never asserted.
  - Required response: resp_valid with resp_err = 1 and resp_timeout = 1 after 8 cycles in CMD; then IDLE with req_ready = 1.
- REQ-037 Reset in RSP:
  - Stimulus: rst_n low for 2 cycles while in RSP, then a stray icb_rsp_valid.
  - Required response: all outputs at reset values, and no resp_valid is produced.
